// File: rtl/sonar_scan_if.sv
// Pin/result bundle between sonar_scan_ctrl and its sensors, calculator and consumers.
// The near[] flags exist only when SONAR_NEAR_ALARM_EN is defined.
interface sonar_scan_if #(
  parameter int unsigned N_SENSORS = 3
) ();
  localparam int unsigned DIST_W = 14;
  localparam int unsigned TIME_W = 16;

  logic                          run;
  logic [N_SENSORS-1:0]          echo;
  logic [N_SENSORS-1:0]          trig;
  logic [TIME_W-1:0]             calc_time;
  logic [DIST_W-1:0]             calc_dis;
  logic [DIST_W*N_SENSORS-1:0]   dist_flat;
  logic [N_SENSORS-1:0]          dist_valid;
  logic [N_SENSORS-1:0]          timeout;
  logic                          busy;
`ifdef SONAR_NEAR_ALARM_EN
  logic [N_SENSORS-1:0]          near;
`endif

  modport master (
    input  run, echo, calc_dis,
    output trig, calc_time, dist_flat, dist_valid, timeout, busy
`ifdef SONAR_NEAR_ALARM_EN
    , output near
`endif
  );

  modport slave (
    output run, echo, calc_dis,
    input  trig, calc_time, dist_flat, dist_valid, timeout, busy
`ifdef SONAR_NEAR_ALARM_EN
    , input near
`endif
  );
endinterface

// File: rtl/sonar_scan_ctrl.sv
// Round-robin trigger/echo timer for N ultrasonic rangers sharing one echo-to-distance
// calculator. Define SONAR_NEAR_ALARM_EN to add registered per-sensor near-obstacle flags.
module sonar_scan_ctrl #(
  parameter int unsigned N_SENSORS       = 3,
  parameter int unsigned CLK_PER_US      = 100,
  parameter int unsigned TRIG_US         = 10,
  parameter int unsigned ECHO_TIMEOUT_US = 30000,
  parameter int unsigned GAP_US          = 20000,
  parameter int unsigned MULT_LAT        = 3
`ifdef SONAR_NEAR_ALARM_EN
  , parameter int unsigned NEAR_MM       = 300
`endif
) (
  input logic          CLK,
  input logic          RST,
  sonar_scan_if.master bus
);
  localparam int unsigned DIST_W   = 14;
  localparam int unsigned TIME_W   = 16;
  localparam int unsigned SEL_W    = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  localparam int unsigned PSC_W    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned US_MAX_A = (TRIG_US > GAP_US) ? TRIG_US : GAP_US;
  localparam int unsigned US_MAX   = (US_MAX_A > ECHO_TIMEOUT_US) ? US_MAX_A : ECHO_TIMEOUT_US;
  localparam int unsigned US_W     = $clog2(US_MAX + 1);
  localparam int unsigned LAT_W    = $clog2(MULT_LAT + 1) + 1;

  localparam logic [PSC_W-1:0] PSC_LAST  = PSC_W'(CLK_PER_US - 1);
  localparam logic [US_W-1:0]  TRIG_LAST = US_W'(TRIG_US - 1);
  localparam logic [US_W-1:0]  TMO_LAST  = US_W'(ECHO_TIMEOUT_US - 1);
  localparam logic [US_W-1:0]  GAP_LAST  = US_W'(GAP_US - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MULT_LAT);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(N_SENSORS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_CALC, S_TMO, S_GAP
  } state_e;

  state_e                      state_q, state_d;
  logic [SEL_W-1:0]            sel_q, sel_d;
  logic [PSC_W-1:0]            psc_q;
  logic [US_W-1:0]             us_q;
  logic [LAT_W-1:0]            lat_q;
  logic [N_SENSORS-1:0]        echo_s1_q, echo_s2_q;
  logic [N_SENSORS-1:0]        trig_q, trig_d;
  logic                        busy_q, busy_d;
  logic [TIME_W-1:0]           calc_time_q;
  logic [DIST_W*N_SENSORS-1:0] dist_flat_q;
  logic [N_SENSORS-1:0]        dist_valid_q;
  logic [N_SENSORS-1:0]        timeout_q;

  logic                        tick_c;
  logic                        echo_sel_c;
  logic [N_SENSORS-1:0]        sel_oh_c;
  logic                        ld_time_c;
  logic                        store_c;
  logic                        store_tmo_c;

  assign tick_c     = (psc_q == PSC_LAST);
  assign echo_sel_c = echo_s2_q[sel_q];
  assign sel_oh_c   = N_SENSORS'(1) << sel_q;

  // Two-flop synchroniser; raw echo pins are asynchronous to CLK
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      echo_s1_q <= '0;
      echo_s2_q <= '0;
    end else begin
      echo_s1_q <= bus.echo;
      echo_s2_q <= echo_s1_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ld_time_c   = 1'b0;
    store_c     = 1'b0;
    store_tmo_c = 1'b0;
    case (state_q)
      S_IDLE:      if (bus.run) state_d = S_TRIG;
      S_TRIG:      if (tick_c && (us_q == TRIG_LAST)) state_d = S_WAIT_RISE;
      // A level check doubles as rise detection: echo already high at entry counts as a rise
      S_WAIT_RISE: begin
        if (echo_sel_c)                          state_d = S_MEASURE;
        else if (tick_c && (us_q == TMO_LAST))   state_d = S_TMO;
      end
      S_MEASURE: begin
        if (!echo_sel_c) begin
          state_d   = S_CALC;
          ld_time_c = 1'b1;
        end else if (tick_c && (us_q == TMO_LAST)) begin
          state_d   = S_TMO;
        end
      end
      S_CALC: begin
        if (lat_q == LAT_LAST) begin
          state_d = S_GAP;
          store_c = 1'b1;
        end
      end
      S_TMO: begin
        state_d     = S_GAP;
        store_c     = 1'b1;
        store_tmo_c = 1'b1;
      end
      S_GAP: begin
        if (tick_c && (us_q == GAP_LAST)) begin
          sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
          state_d = bus.run ? S_TRIG : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    trig_d = (state_d == S_TRIG) ? (N_SENSORS'(1) << sel_d) : '0;
    busy_d = (state_d != S_IDLE);
  end

  // Timebase restarts on every state change so each phase length is cycle-exact
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      psc_q <= '0;
      us_q  <= '0;
      lat_q <= '0;
    end else if (state_d != state_q) begin
      psc_q <= '0;
      us_q  <= '0;
      lat_q <= '0;
    end else begin
      psc_q <= tick_c ? '0 : psc_q + 1'b1;
      if (tick_c)             us_q  <= us_q + 1'b1;
      if (state_q == S_CALC)  lat_q <= lat_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      trig_q       <= '0;
      busy_q       <= 1'b0;
      calc_time_q  <= '0;
      dist_flat_q  <= '0;
      dist_valid_q <= '0;
      timeout_q    <= '0;
    end else begin
      trig_q       <= trig_d;
      busy_q       <= busy_d;
      dist_valid_q <= store_c ? sel_oh_c : '0;
      if (ld_time_c) calc_time_q <= TIME_W'(us_q);
      if (store_c) begin
        dist_flat_q[int'(sel_q)*DIST_W +: DIST_W] <= store_tmo_c ? {DIST_W{1'b1}} : bus.calc_dis;
        timeout_q[sel_q] <= store_tmo_c;
      end
    end
  end

`ifdef SONAR_NEAR_ALARM_EN
  logic [N_SENSORS-1:0] near_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      near_q <= '0;
    end else if (store_c) begin
      near_q[sel_q] <= !store_tmo_c && (bus.calc_dis < DIST_W'(NEAR_MM));
    end
  end

  assign bus.near = near_q;
`endif

  assign bus.trig       = trig_q;
  assign bus.busy       = busy_q;
  assign bus.calc_time  = calc_time_q;
  assign bus.dist_flat  = dist_flat_q;
  assign bus.dist_valid = dist_valid_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_sonar_scan_ctrl.sv
// Directed bench for sonar_scan_ctrl with scaled-down timing and a 3-cycle calculator model.
// Build with SONAR_NEAR_ALARM_EN defined to also check the near[] flags.
module tb_sonar_scan_ctrl;
  localparam int unsigned N        = 3;
  localparam int unsigned CPU      = 2;
  localparam int unsigned TRIG_US  = 10;
  localparam int unsigned TO_US    = 8000;
  localparam int unsigned GAP_US   = 100;
  localparam int unsigned LAT      = 3;
  localparam int unsigned TC       = TRIG_US * CPU;
  localparam int unsigned TOC      = TO_US * CPU;
  localparam int unsigned GAPC     = GAP_US * CPU;
  // echo fall -> dist_valid: 2 sync flops, 1 fall-detect cycle, LAT+1 calc cycles
  localparam int unsigned CALC_LAT = LAT + 4;
  localparam int unsigned LIMIT    = TC + TOC + GAPC + 1000;
  localparam int unsigned N_TRIG   = 11;

  logic CLK;
  logic RST;

  sonar_scan_if #(.N_SENSORS(N)) bus ();

  sonar_scan_ctrl #(
    .N_SENSORS      (N),
    .CLK_PER_US     (CPU),
    .TRIG_US        (TRIG_US),
    .ECHO_TIMEOUT_US(TO_US),
    .GAP_US         (GAP_US),
    .MULT_LAT       (LAT)
`ifdef SONAR_NEAR_ALARM_EN
    , .NEAR_MM      (300)
`endif
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Shared calculator: distance = time*170 >> 10, LAT cycles of latency
  logic [13:0] pipe [LAT];
  always @(posedge CLK) begin
    pipe[0] <= 14'((32'(bus.calc_time) * 32'd170) >> 10);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.calc_dis = pipe[LAT-1];

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int unsigned trig_idx_q [$];
  int unsigned trig_cyc_q [$];
  logic [N-1:0] trig_prev = '0;
  bit multi_hot = 1'b0;
  always @(negedge CLK) begin
    if (!$onehot0(bus.trig)) multi_hot = 1'b1;
    if (bus.trig != '0 && trig_prev == '0) begin
      for (int i = 0; i < N; i++) begin
        if (bus.trig[i]) begin
          trig_idx_q.push_back(i);
          trig_cyc_q.push_back(cyc);
        end
      end
    end
    trig_prev = bus.trig;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [13:0]  exp_dist [N];
  logic [N-1:0] exp_tmo;
`ifdef SONAR_NEAR_ALARM_EN
  logic [N-1:0] exp_near;
`endif

  function automatic logic [14*N-1:0] pack_dist();
    logic [14*N-1:0] v;
    for (int i = 0; i < N; i++) v[i*14 +: 14] = exp_dist[i];
    return v;
  endfunction

  task automatic wait_trig(input int unsigned idx, output int unsigned width);
    int unsigned n;
    n = 0;
    width = 0;
    while (bus.trig[idx] !== 1'b1 && n < LIMIT) begin
      @(negedge CLK);
      n++;
    end
    check_eq($sformatf("trig%0d_seen", idx), 64'(bus.trig[idx]), 64'(1));
    while (bus.trig[idx] === 1'b1 && width < LIMIT) begin
      @(negedge CLK);
      width++;
    end
  endtask

  // Echo held one cycle past w_us whole microseconds to cover the rise-detect cycle
  task automatic drive_echo(input int unsigned idx, input int unsigned w_us, input bit drop);
    int unsigned h;
    h = w_us * CPU + 1;
    bus.echo[idx] = 1'b1;
    for (int unsigned k = 0; k < h; k++) begin
      @(negedge CLK);
      if (drop && k == 100) bus.run = 1'b0;
    end
    bus.echo[idx] = 1'b0;
  endtask

  task automatic wait_valid(input int unsigned idx, output int unsigned n);
    n = 0;
    while (bus.dist_valid === '0 && n < LIMIT) begin
      @(negedge CLK);
      n++;
    end
    check_eq($sformatf("valid%0d_onehot", idx), 64'(bus.dist_valid), 64'(N'(1) << idx));
  endtask

  // One sensor slot: trigger width, echo (w_us=0 means none), latency, stored result
  task automatic service(input int unsigned idx, input int unsigned w_us,
                         input logic [13:0] exp_mm, input bit drop);
    int unsigned width, n;
    wait_trig(idx, width);
    check_eq($sformatf("trig%0d_width", idx), 64'(width), 64'(TC));
    if (w_us != 0) drive_echo(idx, w_us, drop);
    wait_valid(idx, n);
    if (w_us != 0) begin
      check_eq("calc_lat", 64'(n), 64'(CALC_LAT));
      check_eq("calc_time", 64'(bus.calc_time), 64'(w_us));
    end else begin
      check_eq("tmo_lat", 64'(n), 64'(TOC + 1));
    end
    exp_dist[idx] = exp_mm;
    exp_tmo[idx]  = (w_us == 0);
    check_eq($sformatf("dist_flat_s%0d", idx), 64'(bus.dist_flat), 64'(pack_dist()));
    check_eq($sformatf("timeout_s%0d", idx), 64'(bus.timeout), 64'(exp_tmo));
`ifdef SONAR_NEAR_ALARM_EN
    exp_near[idx] = (w_us != 0) && (exp_mm < 14'd300);
    check_eq($sformatf("near_s%0d", idx), 64'(bus.near), 64'(exp_near));
`endif
    @(negedge CLK);
    check_eq("valid_one_pulse", 64'(bus.dist_valid), 64'(0));
    check_eq("dist_hold", 64'(bus.dist_flat), 64'(pack_dist()));
  endtask

  int unsigned exp_order [N_TRIG] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 0};
  int unsigned exp_sp [6];

  initial begin
    int unsigned width;
    for (int i = 0; i < N; i++) exp_dist[i] = '0;
    exp_tmo = '0;
`ifdef SONAR_NEAR_ALARM_EN
    exp_near = '0;
`endif
    exp_sp[0] = TC + (1000 * CPU + 1) + CALC_LAT + GAPC;
    exp_sp[1] = TC + (5882 * CPU + 1) + CALC_LAT + GAPC;
    exp_sp[2] = TC + TOC + 1 + GAPC;
    exp_sp[3] = TC + (100 * CPU + 1) + CALC_LAT + GAPC;
    exp_sp[4] = TC + (100 * CPU + 1) + CALC_LAT + GAPC;
    exp_sp[5] = TC + (1000 * CPU + 1) + CALC_LAT + GAPC;

    bus.run  = 1'b0;
    bus.echo = '0;
    RST      = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("rst_trig", 64'(bus.trig), 64'(0));
    check_eq("rst_busy", 64'(bus.busy), 64'(0));
    check_eq("rst_dist", 64'(bus.dist_flat), 64'(0));
    check_eq("rst_valid", 64'(bus.dist_valid), 64'(0));
    check_eq("rst_timeout", 64'(bus.timeout), 64'(0));
    check_eq("rst_calc_time", 64'(bus.calc_time), 64'(0));
`ifdef SONAR_NEAR_ALARM_EN
    check_eq("rst_near", 64'(bus.near), 64'(0));
`endif
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    check_eq("idle_no_run_busy", 64'(bus.busy), 64'(0));

    bus.run = 1'b1;
    service(0, 1000, 14'd166,   1'b0);
    service(1, 5882, 14'd976,   1'b0);
    service(2, 0,    14'h3FFF,  1'b0);
    service(0, 100,  14'd16,    1'b0);
    service(1, 100,  14'd16,    1'b0);
    service(2, 1000, 14'd166,   1'b0);
    service(0, 100,  14'd16,    1'b0);

    // run dropped mid-measurement: slot completes, GAP runs out, then IDLE
    service(1, 1000, 14'd166, 1'b1);
    repeat (GAPC - 2) @(negedge CLK);
    check_eq("gap_last_busy", 64'(bus.busy), 64'(1));
    @(negedge CLK);
    check_eq("idle_busy", 64'(bus.busy), 64'(0));
    repeat (20) @(negedge CLK);
    check_eq("idle_trig", 64'(bus.trig), 64'(0));
    check_eq("idle_no_new_trig", 64'(trig_idx_q.size()), 64'(8));
    bus.run = 1'b1;
    service(2, 100, 14'd16, 1'b0);

    // Asynchronous reset in the middle of MEASURE
    wait_trig(0, width);
    bus.echo[0] = 1'b1;
    repeat (50) @(negedge CLK);
    RST = 1'b0;
    #1;
    check_eq("arst_trig", 64'(bus.trig), 64'(0));
    check_eq("arst_dist", 64'(bus.dist_flat), 64'(0));
    check_eq("arst_timeout", 64'(bus.timeout), 64'(0));
    check_eq("arst_busy", 64'(bus.busy), 64'(0));
`ifdef SONAR_NEAR_ALARM_EN
    check_eq("arst_near", 64'(bus.near), 64'(0));
    exp_near = '0;
`endif
    for (int i = 0; i < N; i++) exp_dist[i] = '0;
    exp_tmo = '0;
    bus.echo[0] = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    service(0, 5882, 14'd976, 1'b0);

    check_eq("trig_onehot", 64'(multi_hot), 64'(0));
    check_eq("trig_count", 64'(trig_idx_q.size()), 64'(N_TRIG));
    for (int i = 0; i < N_TRIG; i++) begin
      if (i < trig_idx_q.size())
        check_eq($sformatf("trig_order%0d", i), 64'(trig_idx_q[i]), 64'(exp_order[i]));
    end
    for (int i = 0; i < 6; i++) begin
      if (i + 1 < trig_cyc_q.size())
        check_eq($sformatf("trig_spacing%0d", i), 64'(trig_cyc_q[i+1] - trig_cyc_q[i]),
                 64'(exp_sp[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation exceeded 200000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
